// File: rtl/icache_refill_controller.sv
// Instruction-cache line refill sequencer: on a fetch miss, stall, request the line, fill it, replay the lookup.
// Latency: stall lasts 1 + L + 1 + 1 cycles for a memory latency of L cycles (L >= 1).
// Backpressure: the pipeline is held by stall; memory is held by mem_req until mem_ready or timeout.
// Ports: clk/rst (sync, active-high); fetch_valid/address/hit from fetch and cache;
//        mem_req/mem_addr/mem_ready/mem_data to main memory; fill_en/fill_addr/fill_data to cache;
//        stall to the pipeline; miss_count (saturating) and mem_err (sticky timeout flag).
module icache_refill_controller #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic              hit,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_data,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic [CNT_W-1:0]  miss_count,
  output logic              mem_err
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_data;
  logic [TO_W-1:0]   r_to_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              r_err;

  logic w_stall;
  logic w_req;
  logic w_fill;
  logic w_miss_start;
  logic w_got;
  logic w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_fill       = 1'b0;
    w_miss_start = 1'b0;
    w_got        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = fetch_valid & ~hit;
        if (fetch_valid && !hit) begin
          w_miss_start = 1'b1;
          w_next       = MISS;
        end
      end
      MISS: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        // A line arriving on the last allowed cycle still counts.
        if (mem_ready) begin
          w_got  = 1'b1;
          w_next = FILL;
        end else if (r_to_cnt == TO_MAX) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      FILL: begin
        w_stall = 1'b1;
        w_fill  = 1'b1;
        w_next  = REPLAY;
      end
      REPLAY: begin
        // Cache re-evaluates hit on the freshly written line this cycle.
        w_stall = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_to_cnt   <= '0;
      r_miss_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_miss_start) begin
        // Line-align by clearing the byte-within-line bits.
        r_addr   <= address & ~ADDR_W'(15);
        r_to_cnt <= '0;
      end else if (r_state == MISS) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_got) r_data <= mem_data;
      if (w_fill && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // The stall must drop while reset is held, even mid-refill.
  assign stall      = w_stall & ~rst;
  assign mem_req    = w_req;
  assign mem_addr   = r_addr;
  assign fill_en    = w_fill;
  assign fill_addr  = r_addr;
  assign fill_data  = r_data;
  assign miss_count = r_miss_cnt;
  assign mem_err    = r_err;

endmodule

// File: tb/tb_icache_refill_controller.sv
module tb_icache_refill_controller;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_valid;
  logic [ADDR_W-1:0] address;
  logic              hit;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_data;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic [CNT_W-1:0]  miss_count;
  logic              mem_err;

  icache_refill_controller #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .address(address), .hit(hit),
    .mem_ready(mem_ready), .mem_data(mem_data), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .miss_count(miss_count), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: a refill is described by when the request
  // started and when the line arrived; outputs follow from cycle arithmetic.
  int                cyc   = 0;
  bit                busy  = 1'b0;
  int                t_req = -1;
  int                t_got = -1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_data = '0;
  int                m_mc  = 0;
  bit                m_err = 1'b0;

  always @(posedge clk) begin
    int now;
    now = cyc;
    if (rst) begin
      busy = 0; t_req = -1; t_got = -1; m_addr = '0; m_data = '0; m_mc = 0; m_err = 0;
    end else if (!busy) begin
      if (fetch_valid && !hit) begin
        busy   = 1;
        m_addr = (address / 16) * 16;
        t_req  = now + 1;
        t_got  = -1;
      end
    end else if (t_got < 0) begin
      if (mem_ready) begin
        m_data = mem_data;
        t_got  = now;
      end else if (now - t_req == TIMEOUT - 1) begin
        busy  = 0;
        m_err = 1;
      end
    end else if (now == t_got + 1) begin
      if (m_mc < (1 << CNT_W) - 1) m_mc = m_mc + 1;
    end else if (now == t_got + 2) begin
      busy = 0;
    end
    cyc = cyc + 1;
  end

  int                stall_cnt, req_cnt, fill_cnt;
  logic [ADDR_W-1:0] first_req_addr, last_req_addr, last_fill_addr;
  logic [LINE_W-1:0] last_fill_data;

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_stall, e_req, e_fill;
      e_req   = busy && (t_got < 0);
      e_fill  = busy && (t_got >= 0) && (cyc == t_got + 1);
      e_stall = rst ? 1'b0 : (busy ? 1'b1 : (fetch_valid & ~hit));
      chk("stall", LINE_W'(stall), LINE_W'(e_stall));
      chk("mem_req", LINE_W'(mem_req), LINE_W'(e_req));
      chk("mem_addr", LINE_W'(mem_addr), LINE_W'(m_addr));
      chk("fill_en", LINE_W'(fill_en), LINE_W'(e_fill));
      chk("fill_addr", LINE_W'(fill_addr), LINE_W'(m_addr));
      chk("fill_data", fill_data, m_data);
      chk("miss_count", LINE_W'(miss_count), LINE_W'(m_mc));
      chk("mem_err", LINE_W'(mem_err), LINE_W'(m_err));
      if (stall) stall_cnt++;
      if (mem_req) begin
        if (req_cnt == 0) first_req_addr = mem_addr;
        last_req_addr = mem_addr;
        req_cnt++;
      end
      if (fill_en) begin
        fill_cnt++;
        last_fill_addr = fill_addr;
        last_fill_data = fill_data;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; fill_cnt = 0;
    first_req_addr = 'x; last_req_addr = 'x; last_fill_addr = 'x; last_fill_data = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  localparam logic [LINE_W-1:0] LINE_A = 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00;

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; address = '0; hit = 1'b0; mem_ready = 1'b0; mem_data = '0;
    clr();
    step(1);
    chk_en = 1'b1;

    // Reset then hit
    do_reset();
    chk("rst_miss_count", LINE_W'(miss_count), '0);
    chk("rst_mem_err", LINE_W'(mem_err), '0);
    chk("rst_fill_data", fill_data, '0);
    clr();
    fetch_valid = 1'b1; hit = 1'b1; address = 32'h08;
    step(4);
    chk("hit_stall_cycles", LINE_W'(stall_cnt), LINE_W'(0));
    chk("hit_req_cycles", LINE_W'(req_cnt), LINE_W'(0));

    // Miss with L=3
    clr();
    hit = 1'b0; address = 32'h0000_0008;
    step(3);
    mem_ready = 1'b1; mem_data = LINE_A;
    step(1);
    mem_ready = 1'b0; mem_data = '0; hit = 1'b1;
    step(4);
    chk("l3_stall_cycles", LINE_W'(stall_cnt), LINE_W'(6));
    chk("l3_req_cycles", LINE_W'(req_cnt), LINE_W'(3));
    chk("l3_req_addr", LINE_W'(first_req_addr), LINE_W'(32'h0));
    chk("l3_fill_cycles", LINE_W'(fill_cnt), LINE_W'(1));
    chk("l3_fill_addr", LINE_W'(last_fill_addr), LINE_W'(32'h0));
    chk("l3_fill_data", last_fill_data, LINE_A);
    chk("l3_miss_count", LINE_W'(miss_count), LINE_W'(1));

    // Spurious mem_ready in IDLE, then zero-wait memory
    clr();
    mem_ready = 1'b1; mem_data = 128'h1234;
    step(1);
    mem_ready = 1'b0;
    chk("spurious_ready_stall", LINE_W'(stall_cnt), LINE_W'(0));
    hit = 1'b0; address = 32'h0000_004C;
    step(1);
    mem_ready = 1'b1; mem_data = 128'hABCD_0001;
    step(1);
    mem_ready = 1'b0; hit = 1'b1;
    step(3);
    chk("zw_stall_cycles", LINE_W'(stall_cnt), LINE_W'(4));
    chk("zw_fill_addr", LINE_W'(last_fill_addr), LINE_W'(32'h40));
    chk("zw_fill_data", last_fill_data, 128'hABCD_0001);
    chk("zw_miss_count", LINE_W'(miss_count), LINE_W'(2));

    // Timeout, then retry completes with the error flag still set
    clr();
    hit = 1'b0; address = 32'h0000_0024;
    step(5);
    chk("to_req_cycles", LINE_W'(req_cnt), LINE_W'(4));
    chk("to_mem_err", LINE_W'(mem_err), LINE_W'(1));
    chk("to_mem_req_dropped", LINE_W'(mem_req), LINE_W'(0));
    chk("to_no_fill", LINE_W'(fill_cnt), LINE_W'(0));
    step(1);
    mem_ready = 1'b1; mem_data = 128'h5555;
    step(1);
    mem_ready = 1'b0; hit = 1'b1;
    step(3);
    chk("retry_fill_cycles", LINE_W'(fill_cnt), LINE_W'(1));
    chk("retry_fill_addr", LINE_W'(last_fill_addr), LINE_W'(32'h20));
    chk("retry_mem_err", LINE_W'(mem_err), LINE_W'(1));
    chk("retry_miss_count", LINE_W'(miss_count), LINE_W'(3));

    // Reset on the second MISS cycle
    clr();
    hit = 1'b0; address = 32'h0000_0088;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; hit = 1'b1;
    chk("rstmid_mem_req", LINE_W'(mem_req), LINE_W'(0));
    step(3);
    chk("rstmid_no_fill", LINE_W'(fill_cnt), LINE_W'(0));
    chk("rstmid_stall_cycles", LINE_W'(stall_cnt), LINE_W'(2));
    chk("rstmid_miss_count", LINE_W'(miss_count), LINE_W'(0));
    chk("rstmid_mem_err", LINE_W'(mem_err), LINE_W'(0));

    // Back-to-back misses
    clr();
    hit = 1'b0; address = 32'h08;
    step(1);
    mem_ready = 1'b1; mem_data = 128'h11;
    step(1);
    mem_ready = 1'b0; address = 32'h14;
    step(2);
    step(1);
    mem_ready = 1'b1; mem_data = 128'h22;
    step(1);
    mem_ready = 1'b0; hit = 1'b1;
    step(3);
    chk("b2b_first_addr", LINE_W'(first_req_addr), LINE_W'(32'h00));
    chk("b2b_last_addr", LINE_W'(last_req_addr), LINE_W'(32'h10));
    chk("b2b_fill_cycles", LINE_W'(fill_cnt), LINE_W'(2));
    chk("b2b_miss_count", LINE_W'(miss_count), LINE_W'(2));

    // Saturation of miss_count
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hit = 1'b0; address = 32'(i * 16);
      step(1);
      mem_ready = 1'b1;
      step(1);
      mem_ready = 1'b0; hit = 1'b1;
      step(2);
    end
    chk("sat_miss_count", LINE_W'(miss_count), LINE_W'(CNT_MAX));

    // Randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      hit         = ($urandom_range(0, 2) == 0);
      address     = $urandom;
      mem_ready   = ($urandom_range(0, 2) == 0);
      mem_data    = {$urandom, $urandom, $urandom, $urandom};
      step(1);
    end
    rst = 1'b0; fetch_valid = 1'b0; mem_ready = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
- Sequences the fetch-stage instruction cache (4-word, 128-bit lines) on a miss.
- On a miss, the block stalls the pipeline and fetches the missing line from main memory over a req/ready handshake.
- It then writes the line into the cache and replays the lookup before releasing the stall.
- It sits between the fetch stage, the instruction cache and the main-memory port, and also keeps a miss counter and a memory-timeout error flag.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 128, cache line width (4 x 32-bit words).
- TIMEOUT, 64, maximum cycles to wait for mem_ready before abort (>=2).
- CNT_W, 16, width of miss_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch stage presents a valid address this cycle.
- address  in  ADDR_W  fetch byte address (same value driven to the cache).
- hit  in  1  cache lookup result for address.
- mem_ready  in  1  main memory returns line; one-cycle pulse.
- mem_data  in  LINE_W  line data, valid when mem_ready=1.
- stall  out  1  freeze PC/IF-ID.
- mem_req  out  1  line request to main memory.
- mem_addr  out  ADDR_W  line-aligned request address (low 4 bits zero).
- fill_en  out  1  cache write strobe.
- fill_addr  out  ADDR_W  line-aligned fill address.
- fill_data  out  LINE_W  line to write (cache mem_in).
- miss_count  out  CNT_W  number of misses serviced.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- One clock (clk); synchronous active-high reset (rst). All state changes on the rising edge of clk.
- Reset values:
  - state=IDLE.
  - mem_req=0, mem_addr=0.
  - fill_en=0, fill_addr=0, fill_data=0.
  - miss_count=0, mem_err=0.
  - Timeout counter=0.
- stall=0 while rst=1. A rst asserted mid-refill aborts the refill immediately: no fill occurs and the stall is released.
- IDLE:
  - stall = fetch_valid & ~hit (combinational), so a hit never stalls.
  - On fetch_valid & ~hit: latch {address[ADDR_W-1:4],4'b0} into mem_addr and fill_addr, clear the timeout counter, and go to MISS.
- MISS:
  - stall=1, mem_req=1; mem_addr is held stable.
  - The timeout counter increments each cycle.
  - mem_ready=1: capture mem_data into fill_data, drop mem_req, and go to FILL. mem_ready in the first MISS cycle is legal, giving minimum MISS length = 1 cycle.
  - Counter reaches TIMEOUT-1 without mem_ready: drop mem_req, set mem_err=1 (sticky until rst), and go to IDLE. No fill occurs, and the next cycle re-misses and retries.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- FILL:
  - stall=1, fill_en=1 for exactly one cycle; fill_addr and fill_data are stable.
  - miss_count increments, saturating at all-ones (no wrap).
  - Go to REPLAY.
- REPLAY:
  - stall=1 for one cycle while the cache re-evaluates hit on the filled line.
  - Go to IDLE, where a hit releases the stall.
- Latency: miss with memory latency L (cycles of mem_req before mem_ready, L>=1) gives stall for 1 (IDLE detect) + L + 1 (FILL) + 1 (REPLAY) cycles.
- Inputs ignored outside their states:
  - mem_ready outside MISS is ignored.
  - address and fetch_valid changes during MISS/FILL/REPLAY are ignored, since the pipeline is frozen.
- Illegal state encodings return to IDLE.

Test Plan:
- Reset then hit: rst=1 for 2 cycles, then fetch_valid=1, hit=1, address=0x08 -> stall=0, mem_req=0, miss_count=0 throughout.
- Miss with L=3: address=0x0000_0008, hit=0 -> mem_addr=0x0000_0000, mem_req high 3 cycles. On mem_ready with mem_data=0xFFFFFFFF_00000000_FFFFFFFF_00007C00: fill_en pulses 1 cycle with that data at fill_addr=0x0. Stall lasts 6 cycles; miss_count=1.
- Zero-wait memory: mem_ready=1 on the first MISS cycle -> fill_en on the next cycle, total stall 4 cycles. A spurious mem_ready in IDLE is ignored.
- Timeout with TIMEOUT=4 and no mem_ready: mem_req high 4 cycles, then mem_err=1 and mem_req=0. The immediate re-miss restarts the request; a subsequent mem_ready completes the fill while mem_err stays 1.
- Reset mid-refill: assert rst on the 2nd MISS cycle -> next cycle mem_req=0, fill_en never asserts, stall=0, miss_count=0.
- Back-to-back misses: address 0x08 miss then 0x14 miss -> mem_addr 0x00 then 0x10, two fills, miss_count=2.
